// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment width,
// blank pattern and the lit-high hex glyph table (bit6=a ... bit0=g).
package seven_seg_scan_driver_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = '0;

   // Entry n is the glyph for nibble n; listed F down to 0 so index n lands on entry n.
   localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
      7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
      7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
      7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
      7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
   };

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seg7.sv
// Combinational nibble to lit-high segment decoder with a forced-blank input.
module hex_to_seg7
   import seven_seg_scan_driver_pkg::*;
(
   input  logic [3:0]       i_nibble,
   input  logic             i_blank,
   output logic [SEG_W-1:0] o_seg
);

   assign o_seg = i_blank ? SEG_BLANK : SEG_TABLE[i_nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous
// double-buffered loading, leading-zero suppression and a blank slot per digit.
module seven_seg_scan_driver
   import seven_seg_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic                    load,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_tick
);

   localparam int   IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int   PSC_W   = $clog2(SCAN_DIV);
   localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
   localparam logic DIG_POL = (DIG_ACTIVE_LOW != 0);

   logic [PSC_W-1:0]        r_psc;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_stage_val, r_shadow_val;
   logic [NUM_DIGITS-1:0]   r_stage_dp, r_shadow_dp;
   logic                    r_stage_lz, r_shadow_lz, r_pending;

   logic [SEG_W-1:0]        r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_sel;
   logic                    r_tick;

   logic                    w_psc_last, w_idx_last, w_wrap;
   logic [NUM_DIGITS-1:0]   w_lz_blank;
   logic [3:0]              w_nibble;
   logic                    w_dp_bit, w_digit_blank;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic [SEG_W-1:0]        w_seg_lit;

   assign w_psc_last = (r_psc == PSC_W'(SCAN_DIV - 1));
   assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
   assign w_wrap     = w_psc_last && w_idx_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_psc <= '0;
         r_idx <= '0;
      end else if (enable_n) begin
         r_psc <= '0;
         r_idx <= '0;
      end else if (w_psc_last) begin
         r_psc <= '0;
         r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end else begin
         r_psc <= r_psc + 1'b1;
      end
   end

   // With the scan stopped there is no frame to tear, so loads go straight to shadow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stage_val  <= '0;
         r_stage_dp   <= '0;
         r_stage_lz   <= 1'b0;
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_shadow_lz  <= 1'b0;
         r_pending    <= 1'b0;
      end else begin
         if (load) begin
            r_stage_val <= value;
            r_stage_dp  <= dp_in;
            r_stage_lz  <= blank_lz;
         end
         if (enable_n) begin
            r_pending <= 1'b0;
            if (load) begin
               r_shadow_val <= value;
               r_shadow_dp  <= dp_in;
               r_shadow_lz  <= blank_lz;
            end else if (r_pending) begin
               r_shadow_val <= r_stage_val;
               r_shadow_dp  <= r_stage_dp;
               r_shadow_lz  <= r_stage_lz;
            end
         end else begin
            if (w_wrap && r_pending) begin
               r_shadow_val <= r_stage_val;
               r_shadow_dp  <= r_stage_dp;
               r_shadow_lz  <= r_stage_lz;
            end
            if (load) begin
               r_pending <= 1'b1;
            end else if (w_wrap) begin
               r_pending <= 1'b0;
            end
         end
      end
   end

   always_comb begin : lz_mask
      logic v_all_zero;
      w_lz_blank = '0;
      v_all_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         v_all_zero    = v_all_zero && (r_shadow_val[4*k +: 4] == 4'h0);
         w_lz_blank[k] = r_shadow_lz && v_all_zero;
      end
   end

   always_comb begin
      w_nibble      = '0;
      w_dp_bit      = 1'b0;
      w_digit_blank = 1'b0;
      w_onehot      = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nibble      = r_shadow_val[4*k +: 4];
            w_dp_bit      = r_shadow_dp[k];
            w_digit_blank = w_lz_blank[k];
            w_onehot[k]   = 1'b1;
         end
      end
   end

   hex_to_seg7 u_hex_to_seg7 (
      .i_nibble (w_nibble),
      .i_blank  (w_digit_blank),
      .o_seg    (w_seg_lit)
   );

   // Prescaler slot 0 is the anti-ghosting gap between digits.
   always_ff @(posedge clk) begin
      if (reset || enable_n || (r_psc == '0)) begin
         r_seg <= {SEG_W{SEG_POL}};
         r_dp  <= SEG_POL;
         r_sel <= {NUM_DIGITS{DIG_POL}};
      end else begin
         r_seg <= w_seg_lit ^ {SEG_W{SEG_POL}};
         r_dp  <= w_dp_bit ^ SEG_POL;
         r_sel <= w_onehot ^ {NUM_DIGITS{DIG_POL}};
      end
      if (reset || enable_n) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign digit_sel  = r_sel;
   assign frame_tick = r_tick;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized plus directed bench for seven_seg_scan_driver against a
// frame-position reference model.
module tb_seven_seg_scan_driver;

   localparam int N  = 4;
   localparam int SD = 4;
   localparam int FRAME = N * SD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        blank_lz = 1'b0;
   logic        load = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  digit_sel;
   logic        frame_tick;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .enable_n(enable_n), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .load(load),
      .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_tick(frame_tick)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Lit-high glyphs for 0..F, a..g.
   logic [6:0] lut [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   bit          m_live = 0;
   int          m_t;
   int          p, slot, d;
   logic [15:0] sh_v, st_v;
   logic [3:0]  sh_dp, st_dp, nib;
   logic        sh_lz, st_lz, pend, lzb;
   logic [6:0]  e_seg;
   logic        e_dp, e_tick;
   logic [3:0]  e_sel;

   // Model: scan position is elapsed enabled cycles modulo the frame length.
   always @(posedge clk) begin
      if (reset) begin
         m_live = 1; m_t = 0;
         sh_v = '0; st_v = '0; sh_dp = '0; st_dp = '0;
         sh_lz = 0; st_lz = 0; pend = 0;
         e_seg = 7'h7F; e_dp = 1; e_sel = 4'hF; e_tick = 0;
      end else if (m_live) begin
         if (enable_n) begin
            e_seg = 7'h7F; e_dp = 1; e_sel = 4'hF; e_tick = 0;
            m_t = 0;
            if (load) begin
               sh_v = value; sh_dp = dp_in; sh_lz = blank_lz;
               st_v = value; st_dp = dp_in; st_lz = blank_lz;
            end else if (pend) begin
               sh_v = st_v; sh_dp = st_dp; sh_lz = st_lz;
            end
            pend = 0;
         end else begin
            p = m_t % FRAME;
            slot = p % SD;
            d = p / SD;
            e_tick = (p == FRAME - 1);
            if (slot == 0) begin
               e_seg = 7'h7F; e_dp = 1; e_sel = 4'hF;
            end else begin
               nib = 4'((sh_v >> (4 * d)) & 16'hF);
               lzb = sh_lz && (d > 0) && ((sh_v >> (4 * d)) == 16'h0);
               e_seg = lzb ? 7'h7F : ~lut[nib];
               e_dp = ~sh_dp[d];
               e_sel = ~(4'b0001 << d);
            end
            if (e_tick && pend) begin
               sh_v = st_v; sh_dp = st_dp; sh_lz = st_lz; pend = 0;
            end
            if (load) begin
               st_v = value; st_dp = dp_in; st_lz = blank_lz; pend = 1;
            end
            m_t++;
         end
      end
      #1;
      if (m_live) begin
         chk("model_seg", 16'(seg), 16'(e_seg));
         chk("model_dp", 16'(dp), 16'(e_dp));
         chk("model_sel", 16'(digit_sel), 16'(e_sel));
         chk("model_tick", 16'(frame_tick), 16'(e_tick));
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic lz);
      value = v; dp_in = dpv; blank_lz = lz; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 4 * FRAME; i++) begin
         step();
         if (frame_tick === 1'b1) return;
      end
      chk("wait_tick_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_sel(input logic [3:0] s);
      for (int i = 0; i < 4 * FRAME; i++) begin
         step();
         if (digit_sel === s) return;
      end
      chk("wait_sel_timeout", 16'(digit_sel), 16'(s));
   endtask

   logic [15:0] rv;
   int sh;

   initial begin
      step(); step();
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_dp", 16'(dp), 16'h1);
      chk("rst_sel", 16'(digit_sel), 16'hF);
      chk("rst_tick", 16'(frame_tick), 16'h0);
      reset = 1'b0;
      step();
      chk("first_blank_sel", 16'(digit_sel), 16'hF);
      step();
      chk("first_active_sel", 16'(digit_sel), 16'b1110);
      chk("first_active_seg", 16'(seg), 16'b0000001);

      do_load(16'h12AF, 4'b0000, 1'b0);
      wait_tick();
      wait_sel(4'b1110); chk("12AF_d0", 16'(seg), 16'b0111000);
      wait_sel(4'b1101); chk("12AF_d1", 16'(seg), 16'b0001000);
      wait_sel(4'b1011); chk("12AF_d2", 16'(seg), 16'b0010010);
      wait_sel(4'b0111); chk("12AF_d3", 16'(seg), 16'b1001111);

      do_load(16'h0050, 4'b0000, 1'b1);
      wait_tick();
      wait_sel(4'b1110); chk("0050_d0", 16'(seg), 16'b0000001);
      wait_sel(4'b1101); chk("0050_d1", 16'(seg), 16'b0100100);
      wait_sel(4'b1011); chk("0050_d2", 16'(seg), 16'h7F);
      wait_sel(4'b0111); chk("0050_d3", 16'(seg), 16'h7F);

      do_load(16'h0000, 4'b0000, 1'b1);
      wait_tick();
      wait_sel(4'b1110); chk("0000_d0", 16'(seg), 16'b0000001);
      wait_sel(4'b1101); chk("0000_d1", 16'(seg), 16'h7F);

      do_load(16'h1111, 4'b0000, 1'b0);
      wait_sel(4'b1011); chk("old_before_tick", 16'(seg), 16'h7F);
      wait_tick();
      wait_sel(4'b1110); chk("1111_d0", 16'(seg), 16'b1001111);

      do_load(16'h2222, 4'b0000, 1'b0);
      do_load(16'h3333, 4'b0100, 1'b0);
      wait_tick();
      wait_sel(4'b1110); chk("3333_d0", 16'(seg), 16'b0000110);
      chk("dp_off_d0", 16'(dp), 16'h1);
      wait_sel(4'b1011); chk("dp_on_d2", 16'(dp), 16'h0);
      wait_sel(4'b0111); chk("dp_off_d3", 16'(dp), 16'h1);

      wait_sel(4'b1011);
      enable_n = 1'b1;
      step();
      chk("dis_sel", 16'(digit_sel), 16'hF);
      chk("dis_seg", 16'(seg), 16'h7F);
      do_load(16'hBEEF, 4'b0000, 1'b0);
      for (int i = 0; i < FRAME + 2; i++) begin
         step();
         chk("dis_tick", 16'(frame_tick), 16'h0);
      end
      enable_n = 1'b0;
      step();
      chk("reen_blank", 16'(digit_sel), 16'hF);
      step();
      chk("reen_sel", 16'(digit_sel), 16'b1110);
      chk("reen_seg", 16'(seg), 16'b0111000);

      for (int i = 0; i < 1500; i++) begin
         step();
         reset = ($urandom_range(0, 299) == 0);
         load = ($urandom_range(0, 6) == 0);
         if (load) begin
            sh = $urandom_range(0, 4);
            rv = 16'($urandom) & (16'hFFFF >> (4 * sh));
            value = rv;
            dp_in = 4'($urandom);
            blank_lz = 1'($urandom);
         end
         if ($urandom_range(0, 39) == 0) enable_n = ~enable_n;
      end
      reset = 1'b0; load = 1'b0; enable_n = 1'b0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
